cpu_wb_port_arbiter: RTL
========================

// Module: cpu_wb_port_arbiter
// PURPOSE
// - Shares the single register-bank write port between the in-order ALU writeback stream and a long-latency (LL) producer (mul/div/load).
// - Buffers LL results in a small FIFO, forces LL drains when a starvation or full limit is reached, and tells the hazard unit via stall_pipe.
// - Exports pending_mask so the hazard unit can stall reads and WAW hazards on registers with a queued LL write.
// PARAMETERS
// - REG_W        32  data width of a register write
// - REG_ID_W     5   register id width; 2**REG_ID_W registers
// - FIFO_DEPTH   4   LL result FIFO entries (power of 2, >=2)
// - STARVE_LIMIT 3   consecutive ALU grants with non-empty FIFO before a forced LL drain
// PORTS
// - clock         in   1          single clock, rising edge
// - reset         in   1          asynchronous, active-low
// - alu_wb_valid  in   1          ALU writeback request this cycle
// - alu_wb_id     in   REG_ID_W   ALU destination register
// - alu_wb_data   in   REG_W      ALU result
// - ll_valid      in   1          LL producer offers a result
// - ll_ready      out  1          FIFO accepts; transfer when ll_valid & ll_ready
// - ll_id         in   REG_ID_W   LL destination register
// - ll_data       in   REG_W      LL result
// - rf_we         out  1          bank write enable (registered)
// - rf_wid        out  REG_ID_W   bank write id (registered)
// - rf_wdata      out  REG_W      bank write data (registered)
// - stall_pipe    out  1          ALU pipe must hold writeback this cycle
// - pending_mask  out  2**REG_ID_W  bit i = some valid FIFO entry targets reg i
// - fifo_count    out  $clog2(FIFO_DEPTH)+1  occupied entries
// - fw_valid/fw_id/fw_data  out  1/REG_ID_W/REG_W  bypass of the in-flight write to the forwarding unit
// BEHAVIOUR
// - Reset (reset==0, async): state=ALU_PRI, FIFO empty, starve_cnt=0, rf_we/rf_wid/rf_wdata=0, stall_pipe=0, fw_*=0, ll_ready=0.
// - ll_ready = !reset_active && fifo_count<FIFO_DEPTH; no bypass, so a full FIFO never accepts even if it pops the same cycle.
// - Push and pop in the same cycle are legal, and count is unchanged. Pointers wrap modulo FIFO_DEPTH.
// - FSM ALU_PRI:
//   - alu_wb_valid -> grant ALU. Otherwise a non-empty FIFO -> grant the head and pop it.
//   - starve_cnt++ when ALU is granted while the FIFO is non-empty; it clears on any LL grant or when the FIFO is empty.
//   - -> LL_FORCE next cycle when starve_cnt reaches STARVE_LIMIT or the FIFO is full at the clock edge.
// - FSM LL_FORCE:
//   - stall_pipe=1, a Moore output from the state. The head is granted and popped, ALU requests are ignored, and the ALU source holds.
//   - Exactly one entry is drained. Next state is ALU_PRI and starve_cnt=0. If the FIFO is still full, it re-enters LL_FORCE next cycle.
//   - The FIFO is never empty in LL_FORCE, by construction.
// - Grant -> rf_we/rf_wid/rf_wdata on the next edge: 1-cycle latency. With no grant, rf_we=0 and id/data hold their previous values.
// - Minimum LL latency from handshake to rf_we is 2 cycles: push, then grant, then register.
// - pending_mask is combinational from valid entries. It clears the cycle after the last matching entry pops.
// - WAW ordering between the ALU and LL is the hazard unit's job, using pending_mask. The arbiter never reorders FIFO entries.
// - Reset asserted mid-operation drops all queued entries and in-flight writes immediately.
// CONFIGURATION
// - CPU_WB_ARB_FWD_EN defined: fw_valid/fw_id/fw_data = rf_we/rf_wid/rf_wdata, giving the forwarding unit a one-cycle-late bypass.
// - CPU_WB_ARB_FWD_EN undefined: the fw_* ports are tied to 0 and no logic is added.
// STRUCTURE
// - cpu_pkg holds: the wb_req_t struct {id, data}, the wb_arb_state_t enum {ALU_PRI, LL_FORCE}, and the default width constants.
// - Sub-module cpu_sync_fifo(DEPTH, WIDTH) is generic. It has push/pop/full/empty/count and exposes entry valid+id for pending_mask.
// TESTING
// - Hold reset low for 2 cycles:
//   - Expect all outputs at 0, with ll_ready=0.
//   - On release, ll_ready=1, fifo_count=0, stall_pipe=0.
// - ALU only, with alu_wb_valid id=2 data=9:
//   - rf_we=1 rf_wid=2 rf_wdata=9 one cycle later.
//   - fw_* match that write when CPU_WB_ARB_FWD_EN is defined, and are 0 otherwise.
// - LL only, one handshake id=5 data=0xAB with ALU idle:
//   - pending_mask[5]=1 for 1 cycle, then rf_we with id=5 data=0xAB two cycles after the handshake.
// - Starvation, ALU valid every cycle after one LL push:
//   - Three ALU grants occur, then stall_pipe=1 for one cycle and the LL entry is written.
//   - starve_cnt returns to 0.
// - Full FIFO, 4 LL pushes while the ALU is busy:
//   - ll_ready=0 at count=4, then LL_FORCE.
//   - Pushing and popping on the same cycle when count=3 keeps count=3.
// - Reset mid-drain with count=3: count=0, pending_mask=0, rf_we=0 immediately, and no stale writes after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and default widths for the CPU writeback port arbiter.
package cpu_pkg;

  localparam int unsigned REG_W_DEF        = 32;
  localparam int unsigned REG_ID_W_DEF     = 5;
  localparam int unsigned FIFO_DEPTH_DEF   = 4;
  localparam int unsigned STARVE_LIMIT_DEF = 3;

  typedef struct packed {
    logic [REG_ID_W_DEF-1:0] id;
    logic [REG_W_DEF-1:0]    data;
  } wb_req_t;

  typedef enum logic {
    ALU_PRI  = 1'b0,
    LL_FORCE = 1'b1
  } wb_arb_state_t;

endpackage

// File: rtl/cpu_sync_fifo.sv
// Generic synchronous FIFO with per-entry valid bits and a tag slice (top TAG_W bits)
// of every entry exposed, so callers can build occupancy masks.
module cpu_sync_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned TAG_W = 1,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [CNT_W-1:0]             count_o,
  output logic [DEPTH-1:0]             entry_valid_o,
  output logic [DEPTH-1:0][TAG_W-1:0]  entry_tag_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [DEPTH-1:0] valid_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
        valid_q[wr_ptr_q] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
        valid_q[rd_ptr_q] <= 1'b0;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; entry_valid_o qualifies every exposed slot.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o       = mem_q[rd_ptr_q];
  assign count_o       = count_q;
  assign entry_valid_o = valid_q;

  generate
    for (genvar gi = 0; gi < int'(DEPTH); gi++) begin : g_tag
      assign entry_tag_o[gi] = mem_q[gi][WIDTH-1 -: TAG_W];
    end
  endgenerate

endmodule

// File: rtl/cpu_wb_port_arbiter.sv
// Shares the register-bank write port between the ALU stream and a FIFO of long-latency results.
// Define CPU_WB_ARB_FWD_EN to drive fw_* from the registered write; otherwise fw_* are tied to 0.
module cpu_wb_port_arbiter
  import cpu_pkg::*;
#(
  parameter  int unsigned REG_W        = REG_W_DEF,
  parameter  int unsigned REG_ID_W     = REG_ID_W_DEF,
  parameter  int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter  int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1,
  localparam int unsigned NREG         = 2 ** REG_ID_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alu_wb_valid_i,
  input  logic [REG_ID_W-1:0]  alu_wb_id_i,
  input  logic [REG_W-1:0]     alu_wb_data_i,
  input  logic                 ll_valid_i,
  output logic                 ll_ready_o,
  input  logic [REG_ID_W-1:0]  ll_id_i,
  input  logic [REG_W-1:0]     ll_data_i,
  output logic                 rf_we_o,
  output logic [REG_ID_W-1:0]  rf_wid_o,
  output logic [REG_W-1:0]     rf_wdata_o,
  output logic                 stall_pipe_o,
  output logic [NREG-1:0]      pending_mask_o,
  output logic [CNT_W-1:0]     fifo_count_o,
  output logic                 fw_valid_o,
  output logic [REG_ID_W-1:0]  fw_id_o,
  output logic [REG_W-1:0]     fw_data_o
);

  localparam int unsigned ENT_W = REG_ID_W + REG_W;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  wb_arb_state_t state_q, state_d;
  logic [STV_W-1:0] starve_q, starve_d;

  logic                           push, pop, full, empty;
  logic                           grant_alu, grant_ll;
  logic [ENT_W-1:0]               head;
  logic [CNT_W-1:0]               count_nxt;
  logic [FIFO_DEPTH-1:0]          entry_valid;
  logic [FIFO_DEPTH-1:0][REG_ID_W-1:0] entry_id;

  logic                rf_we_q;
  logic [REG_ID_W-1:0] rf_wid_q;
  logic [REG_W-1:0]    rf_wdata_q;

  // No bypass: a full FIFO refuses even when it pops this cycle.
  assign ll_ready_o = rst_ni && !full;
  assign push       = ll_valid_i && ll_ready_o;
  assign pop        = grant_ll;
  assign count_nxt  = fifo_count_o + CNT_W'(push) - CNT_W'(pop);

  cpu_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W),
    .TAG_W (REG_ID_W)
  ) u_ll_fifo (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (push),
    .wdata_i       ({ll_id_i, ll_data_i}),
    .pop_i         (pop),
    .rdata_o       (head),
    .full_o        (full),
    .empty_o       (empty),
    .count_o       (fifo_count_o),
    .entry_valid_o (entry_valid),
    .entry_tag_o   (entry_id)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ALU_PRI;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ALU_PRI: begin
        if (grant_alu && !empty) begin
          starve_d = starve_q + STV_W'(1);
        end else begin
          starve_d = '0;
        end
        // Decide on the post-edge view so a drain starts the cycle the limit is hit.
        if (starve_d == STV_W'(STARVE_LIMIT) || count_nxt == CNT_W'(FIFO_DEPTH)) begin
          state_d = LL_FORCE;
        end
      end
      LL_FORCE: begin
        starve_d = '0;
        state_d  = ALU_PRI;
      end
      default: begin
        starve_d = '0;
        state_d  = ALU_PRI;
      end
    endcase
  end

  always_comb begin
    grant_alu    = 1'b0;
    grant_ll     = 1'b0;
    stall_pipe_o = 1'b0;
    case (state_q)
      ALU_PRI: begin
        if (alu_wb_valid_i) begin
          grant_alu = 1'b1;
        end else if (!empty) begin
          grant_ll = 1'b1;
        end
      end
      LL_FORCE: begin
        stall_pipe_o = 1'b1;
        grant_ll     = !empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q    <= 1'b0;
      rf_wid_q   <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= grant_alu || grant_ll;
      if (grant_alu) begin
        rf_wid_q   <= alu_wb_id_i;
        rf_wdata_q <= alu_wb_data_i;
      end else if (grant_ll) begin
        rf_wid_q   <= head[ENT_W-1 -: REG_ID_W];
        rf_wdata_q <= head[REG_W-1:0];
      end
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_wid_o   = rf_wid_q;
  assign rf_wdata_o = rf_wdata_q;

  always_comb begin
    pending_mask_o = '0;
    for (int e = 0; e < int'(FIFO_DEPTH); e++) begin
      if (entry_valid[e]) begin
        pending_mask_o[entry_id[e]] = 1'b1;
      end
    end
  end

`ifdef CPU_WB_ARB_FWD_EN
  assign fw_valid_o = rf_we_q;
  assign fw_id_o    = rf_wid_q;
  assign fw_data_o  = rf_wdata_q;
`else
  assign fw_valid_o = 1'b0;
  assign fw_id_o    = '0;
  assign fw_data_o  = '0;
`endif

endmodule
